// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the rest of the 8-bit CPU: ring-counter
// state, memory data and flags in; PC/ring-counter controls and datapath strobes out.
interface control_sequencer_if;
    logic [14:0] t_state;
    logic [7:0]  mem_data;
    logic        zero_flag;
    logic        carry_flag;
    logic        pc_count;
    logic        pc_load;
    logic [15:0] jump_address;
    logic        pc_out;
    logic        mar_load;
    logic        addr_sel;
    logic        ram_out;
    logic        ram_write;
    logic        a_load;
    logic        a_out;
    logic        b_load;
    logic        alu_out;
    logic        alu_sub;
    logic        flags_load;
    logic        out_load;
    logic        ring_enable;
    logic [1:0]  ring_mode;
    logic [7:0]  opcode;
    logic        halted;
    logic        illegal;

    modport master (
        input  t_state, mem_data, zero_flag, carry_flag,
        output pc_count, pc_load, jump_address, pc_out, mar_load, addr_sel,
               ram_out, ram_write, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, ring_enable, ring_mode, opcode, halted, illegal
    );

    modport slave (
        output t_state, mem_data, zero_flag, carry_flag,
        input  pc_count, pc_load, jump_address, pc_out, mar_load, addr_sel,
               ram_out, ram_write, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, ring_enable, ring_mode, opcode, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Instruction/operand registers plus the T-state x opcode micro-op decoder that
// drives the PC, ring counter and datapath strobes of the 8-bit CPU.
module control_sequencer (
    input  logic                 clk,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h10;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h30;
    localparam logic [7:0] OP_STA = 8'h40;
    localparam logic [7:0] OP_LDI = 8'h50;
    localparam logic [7:0] OP_JMP = 8'h60;
    localparam logic [7:0] OP_JZ  = 8'h70;
    localparam logic [7:0] OP_JC  = 8'h71;
    localparam logic [7:0] OP_OUT = 8'hE0;
    localparam logic [7:0] OP_HLT = 8'hF0;

    localparam logic [1:0] MODE_6  = 2'b00;
    localparam logic [1:0] MODE_10 = 2'b01;
    localparam logic [1:0] MODE_15 = 2'b10;

    logic [7:0] opcode_q, opcode_d;
    logic [7:0] opr_lo_q, opr_lo_d;
    logic [7:0] opr_hi_q, opr_hi_d;
    logic       halted_q, halted_d;
    logic [1:0] ring_mode_q, ring_mode_d;
    logic       illegal_q, illegal_d;

    logic [14:0] t_s;
    logic        onehot_s;
    logic        active_s;
    logic        addr16_s;

    function automatic logic [1:0] mode_of(input logic [7:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mode_of = MODE_15;
            OP_LDI, OP_JMP, OP_JZ, OP_JC:   mode_of = MODE_10;
            default:                        mode_of = MODE_6;
        endcase
    endfunction

    function automatic logic is_defined(input logic [7:0] op);
        case (op)
            OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
            OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT: is_defined = 1'b1;
            default:                              is_defined = 1'b0;
        endcase
    endfunction

    assign t_s      = bus.t_state;
    assign onehot_s = (t_s != 15'd0) && ((t_s & (t_s - 15'd1)) == 15'd0);
    assign active_s = onehot_s && !halted_q;
    assign addr16_s = (opcode_q == OP_LDA) || (opcode_q == OP_ADD) || (opcode_q == OP_SUB) ||
                      (opcode_q == OP_STA) || (opcode_q == OP_JMP) || (opcode_q == OP_JZ) ||
                      (opcode_q == OP_JC);

    // Next-state for the instruction, operand, mode, halt and illegal registers.
    always_comb begin
        opcode_d    = opcode_q;
        opr_lo_d    = opr_lo_q;
        opr_hi_d    = opr_hi_q;
        halted_d    = halted_q;
        ring_mode_d = ring_mode_q;
        illegal_d   = 1'b0;
        if (active_s) begin
            if (t_s[1]) begin
                opcode_d = bus.mem_data;
            end else if (t_s[2]) begin
                ring_mode_d = mode_of(opcode_q);
                illegal_d   = !is_defined(opcode_q);
                halted_d    = (opcode_q == OP_HLT);
            end else if (t_s[3] && addr16_s) begin
                opr_lo_d = bus.mem_data;
            end else if (t_s[5] && addr16_s) begin
                opr_hi_d = bus.mem_data;
            end else begin
                opcode_d = opcode_q;
            end
        end else begin
            illegal_d = 1'b0;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            opcode_q    <= 8'h00;
            opr_lo_q    <= 8'h00;
            opr_hi_q    <= 8'h00;
            halted_q    <= 1'b0;
            ring_mode_q <= 2'b00;
            illegal_q   <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            opr_lo_q    <= opr_lo_d;
            opr_hi_q    <= opr_hi_d;
            halted_q    <= halted_d;
            ring_mode_q <= ring_mode_d;
            illegal_q   <= illegal_d;
        end
    end

    // Micro-op decode: fetch in T0/T1, operand fetch T2..T5, execute afterwards.
    always_comb begin
        bus.pc_count   = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_out     = 1'b0;
        bus.mar_load   = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.ram_out    = 1'b0;
        bus.ram_write  = 1'b0;
        bus.a_load     = 1'b0;
        bus.a_out      = 1'b0;
        bus.b_load     = 1'b0;
        bus.alu_out    = 1'b0;
        bus.alu_sub    = 1'b0;
        bus.flags_load = 1'b0;
        bus.out_load   = 1'b0;
        if (!active_s) begin
            bus.pc_count = 1'b0;
        end else if (t_s[0]) begin
            bus.pc_out   = 1'b1;
            bus.mar_load = 1'b1;
        end else if (t_s[1]) begin
            bus.ram_out  = 1'b1;
            bus.pc_count = 1'b1;
        end else if (addr16_s && (t_s[2] || t_s[4])) begin
            bus.pc_out   = 1'b1;
            bus.mar_load = 1'b1;
        end else if (addr16_s && (t_s[3] || t_s[5])) begin
            bus.ram_out  = 1'b1;
            bus.pc_count = 1'b1;
        end else begin
            case (opcode_q)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    if (t_s[6]) begin
                        bus.addr_sel = 1'b1;
                        bus.mar_load = 1'b1;
                    end else if (t_s[7]) begin
                        bus.ram_out   = (opcode_q != OP_STA);
                        bus.a_load    = (opcode_q == OP_LDA);
                        bus.b_load    = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);
                        bus.a_out     = (opcode_q == OP_STA);
                        bus.ram_write = (opcode_q == OP_STA);
                    end else if (t_s[8] && (opcode_q != OP_LDA) && (opcode_q != OP_STA)) begin
                        bus.alu_out    = 1'b1;
                        bus.a_load     = 1'b1;
                        bus.flags_load = 1'b1;
                        bus.alu_sub    = (opcode_q == OP_SUB);
                    end else begin
                        bus.alu_out = 1'b0;
                    end
                end
                OP_LDI: begin
                    if (t_s[2]) begin
                        bus.pc_out   = 1'b1;
                        bus.mar_load = 1'b1;
                    end else if (t_s[3]) begin
                        bus.ram_out  = 1'b1;
                        bus.a_load   = 1'b1;
                        bus.pc_count = 1'b1;
                    end else begin
                        bus.a_load = 1'b0;
                    end
                end
                OP_JMP: bus.pc_load = t_s[6];
                OP_JZ:  bus.pc_load = t_s[6] && bus.zero_flag;
                OP_JC:  bus.pc_load = t_s[6] && bus.carry_flag;
                OP_OUT: begin
                    bus.a_out    = t_s[2];
                    bus.out_load = t_s[2];
                end
                default: bus.pc_load = 1'b0;
            endcase
        end
    end

    assign bus.ring_enable  = !halted_q && !(t_s[2] && (opcode_q == OP_HLT));
    assign bus.jump_address = {opr_hi_q, opr_lo_q};
    assign bus.ring_mode    = ring_mode_q;
    assign bus.opcode       = opcode_q;
    assign bus.halted       = halted_q;
    assign bus.illegal      = illegal_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: the bench plays the ring counter and memory,
// stepping T-states one per clock and checking strobes/registers against hand values.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic clear;
    int   errors = 0;
    int   checks = 0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] S_NONE = 14'h0000;
    localparam logic [13:0] S_PCC  = 14'h2000;
    localparam logic [13:0] S_PCL  = 14'h1000;
    localparam logic [13:0] S_PCO  = 14'h0800;
    localparam logic [13:0] S_MAR  = 14'h0400;
    localparam logic [13:0] S_ADS  = 14'h0200;
    localparam logic [13:0] S_RAM  = 14'h0100;
    localparam logic [13:0] S_RMW  = 14'h0080;
    localparam logic [13:0] S_ALD  = 14'h0040;
    localparam logic [13:0] S_AOUT = 14'h0020;
    localparam logic [13:0] S_BLD  = 14'h0010;
    localparam logic [13:0] S_ALUO = 14'h0008;
    localparam logic [13:0] S_SUB  = 14'h0004;
    localparam logic [13:0] S_FLG  = 14'h0002;
    localparam logic [13:0] S_OUTL = 14'h0001;

    logic [13:0] strobes;
    assign strobes = {bus.pc_count, bus.pc_load, bus.pc_out, bus.mar_load, bus.addr_sel,
                      bus.ram_out, bus.ram_write, bus.a_load, bus.a_out, bus.b_load,
                      bus.alu_out, bus.alu_sub, bus.flags_load, bus.out_load};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive T-state n and memory data at the falling edge.
    task automatic cyc(input int n, input logic [7:0] d);
        @(negedge clk);
        bus.t_state  = 15'd1 << n;
        bus.mem_data = d;
        #1;
    endtask

    task automatic fetch(input logic [7:0] op);
        cyc(0, 8'h00);
        chk("fetch_t0", {18'd0, strobes}, {18'd0, S_PCO | S_MAR});
        cyc(1, op);
        chk("fetch_t1", {18'd0, strobes}, {18'd0, S_RAM | S_PCC});
    endtask

    task automatic addr_fetch(input logic [7:0] lo, input logic [7:0] hi);
        cyc(2, 8'h00);
        chk("opr_t2", {18'd0, strobes}, {18'd0, S_PCO | S_MAR});
        cyc(3, lo);
        chk("opr_t3", {18'd0, strobes}, {18'd0, S_RAM | S_PCC});
        cyc(4, 8'h00);
        chk("opr_t4", {18'd0, strobes}, {18'd0, S_PCO | S_MAR});
        cyc(5, hi);
        chk("opr_t5", {18'd0, strobes}, {18'd0, S_RAM | S_PCC});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear          = 1'b1;
        bus.t_state    = 15'd1;
        bus.mem_data   = 8'h00;
        bus.zero_flag  = 1'b0;
        bus.carry_flag = 1'b0;
        cyc(0, 8'h00);
        cyc(0, 8'h00);
        clear = 1'b0;

        // Reset state, then HLT program
        cyc(0, 8'h00);
        chk("rst_opcode", {24'd0, bus.opcode}, 32'h00);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_mode", {30'd0, bus.ring_mode}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("rst_t0", {18'd0, strobes}, {18'd0, S_PCO | S_MAR});
        cyc(1, 8'hF0);
        chk("hlt_t1", {18'd0, strobes}, {18'd0, S_RAM | S_PCC});
        cyc(2, 8'h00);
        chk("hlt_opcode", {24'd0, bus.opcode}, 32'hF0);
        chk("hlt_t2_str", {18'd0, strobes}, 32'd0);
        chk("hlt_t2_ren", {31'd0, bus.ring_enable}, 32'd0);
        chk("hlt_t2_halt", {31'd0, bus.halted}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(2, 8'h00);
            chk("halted_str", {18'd0, strobes}, 32'd0);
        end
        chk("halted_flag", {31'd0, bus.halted}, 32'd1);
        chk("halted_ren", {31'd0, bus.ring_enable}, 32'd0);
        clear = 1'b1;
        cyc(2, 8'h00);
        clear = 1'b0;
        cyc(5, 8'h00);
        chk("clr_opcode", {24'd0, bus.opcode}, 32'h00);
        chk("clr_halted", {31'd0, bus.halted}, 32'd0);
        chk("clr_ren", {31'd0, bus.ring_enable}, 32'd1);

        // LDA 0x1234
        fetch(8'h10);
        addr_fetch(8'h34, 8'h12);
        chk("lda_mode", {30'd0, bus.ring_mode}, 32'd2);
        cyc(6, 8'h00);
        chk("lda_jaddr", {16'd0, bus.jump_address}, 32'h1234);
        chk("lda_t6", {18'd0, strobes}, {18'd0, S_ADS | S_MAR});
        cyc(7, 8'h00);
        chk("lda_t7", {18'd0, strobes}, {18'd0, S_RAM | S_ALD});
        for (int n = 8; n <= 14; n++) begin
            cyc(n, 8'h00);
            chk("lda_idle", {18'd0, strobes}, 32'd0);
        end

        // JZ 0x00FF, not taken then taken
        for (int z = 0; z < 2; z++) begin
            bus.zero_flag = z[0];
            fetch(8'h70);
            addr_fetch(8'hFF, 8'h00);
            chk("jz_mode", {30'd0, bus.ring_mode}, 32'd1);
            cyc(6, 8'h00);
            chk("jz_jaddr", {16'd0, bus.jump_address}, 32'h00FF);
            chk("jz_t6", {18'd0, strobes}, (z == 1) ? {18'd0, S_PCL} : 32'd0);
            for (int n = 7; n <= 9; n++) begin
                cyc(n, 8'h00);
                chk("jz_idle", {18'd0, strobes}, 32'd0);
            end
        end
        bus.zero_flag = 1'b0;

        // SUB then OUT
        fetch(8'h30);
        addr_fetch(8'h00, 8'h80);
        cyc(6, 8'h00);
        chk("sub_t6", {18'd0, strobes}, {18'd0, S_ADS | S_MAR});
        cyc(7, 8'h00);
        chk("sub_t7", {18'd0, strobes}, {18'd0, S_RAM | S_BLD});
        cyc(8, 8'h00);
        chk("sub_t8", {18'd0, strobes}, {18'd0, S_ALUO | S_ALD | S_SUB | S_FLG});
        chk("sub_mode", {30'd0, bus.ring_mode}, 32'd2);
        fetch(8'hE0);
        cyc(2, 8'h00);
        chk("out_t2_mode", {30'd0, bus.ring_mode}, 32'd2);
        chk("out_t2", {18'd0, strobes}, {18'd0, S_AOUT | S_OUTL});
        cyc(3, 8'h00);
        chk("out_mode", {30'd0, bus.ring_mode}, 32'd0);
        chk("out_t3", {18'd0, strobes}, 32'd0);

        // Undefined opcode 0x99
        fetch(8'h99);
        cyc(2, 8'h00);
        chk("ill_t2_str", {18'd0, strobes}, 32'd0);
        chk("ill_t2_flag", {31'd0, bus.illegal}, 32'd0);
        cyc(3, 8'h00);
        chk("ill_t3_flag", {31'd0, bus.illegal}, 32'd1);
        chk("ill_t3_str", {18'd0, strobes}, 32'd0);
        chk("ill_mode", {30'd0, bus.ring_mode}, 32'd0);
        cyc(4, 8'h00);
        chk("ill_t4_flag", {31'd0, bus.illegal}, 32'd0);
        chk("ill_t4_str", {18'd0, strobes}, 32'd0);
        cyc(5, 8'h00);
        chk("ill_t5_str", {18'd0, strobes}, 32'd0);

        // Non-one-hot T-state while opcode still decodes fetch
        @(negedge clk);
        bus.t_state = 15'h0005;
        #1;
        chk("not_onehot", {18'd0, strobes}, 32'd0);

        // STA interrupted by clear in T7
        fetch(8'h40);
        addr_fetch(8'h78, 8'h56);
        cyc(6, 8'h00);
        chk("sta_t6", {18'd0, strobes}, {18'd0, S_ADS | S_MAR});
        cyc(7, 8'h00);
        chk("sta_t7", {18'd0, strobes}, {18'd0, S_AOUT | S_RMW});
        clear = 1'b1;
        cyc(7, 8'h00);
        clear = 1'b0;
        chk("sta_clr_op", {24'd0, bus.opcode}, 32'h00);
        chk("sta_clr_jaddr", {16'd0, bus.jump_address}, 32'h0000);
        chk("sta_clr_str", {18'd0, strobes}, 32'd0);
        for (int n = 8; n <= 14; n++) begin
            cyc(n, 8'h00);
            chk("sta_no_wr", {31'd0, bus.ram_write}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
